// File: rtl/cpu_pkg.sv
// cpu_pkg: shared backend widths and the CDB broadcast packet
package cpu_pkg;

   localparam int NUM_FU = 4;
   localparam int TAG_W  = 6;
   localparam int PREG_W = 7;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [PREG_W-1:0] preg;
      logic [DATA_W-1:0] data;
   } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after ptr
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_gnt
);

   // scan offsets from far to near so the nearest request to ptr is written last and wins
   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
            any_gnt  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common data bus scheduler with a registered broadcast stage
module cdb_arbiter #(
   parameter int NUM_FU = cpu_pkg::NUM_FU,
   parameter int TAG_W  = cpu_pkg::TAG_W,
   parameter int PREG_W = cpu_pkg::PREG_W,
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int IW     = $clog2(NUM_FU)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NUM_FU-1:0]        fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
   input  logic [NUM_FU*PREG_W-1:0] fu_preg,
   input  logic [NUM_FU*DATA_W-1:0] fu_data,
   output logic [NUM_FU-1:0]        fu_ready,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [PREG_W-1:0]        cdb_preg,
   output logic [DATA_W-1:0]        cdb_data,
   output logic [IW-1:0]            cdb_src
);

   import cpu_pkg::*;

   logic [IW-1:0]     rr_ptr;
   logic [NUM_FU-1:0] gnt;
   logic [IW-1:0]     gnt_idx;
   logic              any_gnt;
   logic              grant;
   cdb_pkt_t          win_pkt;
   cdb_pkt_t          pkt_q;

   rr_arbiter #(.N(NUM_FU), .IW(IW)) u_rr (
      .req     (fu_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // grants are suppressed during flush and while held in reset so nothing is accepted then
   always_comb begin
      grant        = any_gnt & ~flush & rst_n;
      fu_ready     = grant ? gnt : '0;
      win_pkt.tag  = fu_tag[int'(gnt_idx)*TAG_W +: TAG_W];
      win_pkt.preg = fu_preg[int'(gnt_idx)*PREG_W +: PREG_W];
      win_pkt.data = fu_data[int'(gnt_idx)*DATA_W +: DATA_W];
   end

   // capture the winner and advance the pointer past it; payload holds when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         pkt_q     <= '0;
         cdb_src   <= '0;
      end else begin
         cdb_valid <= grant;
         if (grant) begin
            rr_ptr  <= (gnt_idx == IW'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
            pkt_q   <= win_pkt;
            cdb_src <= gnt_idx;
         end
      end
   end

   assign cdb_tag  = pkt_q.tag;
   assign cdb_preg = pkt_q.preg;
   assign cdb_data = pkt_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and scoreboarded checks of the CDB round-robin scheduler
module tb_cdb_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic [N-1:0]  fu_valid;
   logic [N*6-1:0]  fu_tag;
   logic [N*7-1:0]  fu_preg;
   logic [N*32-1:0] fu_data;
   logic [N-1:0]  fu_ready;
   logic          cdb_valid;
   logic [5:0]    cdb_tag;
   logic [6:0]    cdb_preg;
   logic [31:0]   cdb_data;
   logic [1:0]    cdb_src;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_tag    (fu_tag),
      .fu_preg   (fu_preg),
      .fu_data   (fu_data),
      .fu_ready  (fu_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_preg  (cdb_preg),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_fu(input int i, input logic [5:0] t, input logic [6:0] p, input logic [31:0] d);
      fu_tag[i*6 +: 6]   = t;
      fu_preg[i*7 +: 7]  = p;
      fu_data[i*32 +: 32] = d;
   endtask

   task automatic edge_chk(input string tag, input logic v, input logic [1:0] src);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(cdb_valid), 32'(v));
      if (v) chk({tag, "_src"}, 32'(cdb_src), 32'(src));
   endtask

   logic       mv[N];
   logic [5:0] mtag[N];
   logic [31:0] mdat[N];
   int         mwait[N];
   int         mptr;
   int         exp_i;
   logic       mflush;

   initial begin
      rst_n = 1'b0; flush = 1'b0; fu_valid = '1;
      fu_tag = '0; fu_preg = '0; fu_data = '0;
      // reset held with requests present
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("rst_ready", 32'(fu_ready), 0);
         chk("rst_valid", 32'(cdb_valid), 0);
      end
      @(negedge clk); rst_n = 1'b1; fu_valid = '0;
      edge_chk("post_rst", 1'b0, 2'd0);
      edge_chk("post_rst2", 1'b0, 2'd0);
      // single requester FU2
      @(negedge clk);
      set_fu(2, 6'd5, 7'd17, 32'hDEAD_BEEF); fu_valid = 4'b0100; #1;
      chk("fu2_ready", 32'(fu_ready), 32'b0100);
      edge_chk("fu2", 1'b1, 2'd2);
      chk("fu2_tag", 32'(cdb_tag), 5);
      chk("fu2_preg", 32'(cdb_preg), 17);
      chk("fu2_data", cdb_data, 32'hDEAD_BEEF);
      @(negedge clk); fu_valid = '0;
      edge_chk("fu2_idle", 1'b0, 2'd0);
      // all four continuously valid straight out of reset
      @(negedge clk); rst_n = 1'b0; fu_valid = '1;
      for (int i = 0; i < N; i++) set_fu(i, 6'(10 + i), 7'(20 + i), 32'(100 + i));
      @(negedge clk); rst_n = 1'b1; #1;
      chk("all_ready0", 32'(fu_ready), 32'b0001);
      for (int k = 0; k < 6; k++) begin
         edge_chk("all_rr", 1'b1, 2'(k % N));
         chk("all_tag", 32'(cdb_tag), 32'(10 + k % N));
      end
      // FU0 alone moves ptr to 1, then FU0+FU3 -> FU3 then FU0
      @(negedge clk); fu_valid = 4'b0001;
      edge_chk("g0", 1'b1, 2'd0);
      @(negedge clk); fu_valid = 4'b1001; #1;
      chk("p1_ready", 32'(fu_ready), 32'b1000);
      edge_chk("p1_fu3", 1'b1, 2'd3);
      chk("p1_ready2", 32'(fu_ready), 32'b0001);
      edge_chk("p1_fu0", 1'b1, 2'd0);
      // flush blocks grant and leaves ptr at 1
      @(negedge clk); fu_valid = 4'b0110; flush = 1'b1; #1;
      chk("fl_ready", 32'(fu_ready), 0);
      edge_chk("fl", 1'b0, 2'd0);
      @(negedge clk); flush = 1'b0; #1;
      chk("fl_after_ready", 32'(fu_ready), 32'b0010);
      edge_chk("fl_after", 1'b1, 2'd1);
      // async reset in the middle of a broadcast
      #2 rst_n = 1'b0; #1;
      chk("arst_valid", 32'(cdb_valid), 0);
      chk("arst_ready", 32'(fu_ready), 0);
      @(negedge clk); rst_n = 1'b1; fu_valid = '1; #1;
      chk("arst_ptr", 32'(fu_ready), 32'b0001);
      edge_chk("arst_g", 1'b1, 2'd0);
      // random soak against a reference model
      mptr = 1;
      for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mwait[i] = 0; end
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (!mv[i] && $urandom_range(2) == 0) begin
            mv[i] = 1'b1; mtag[i] = 6'($urandom); mdat[i] = $urandom;
            set_fu(i, mtag[i], 7'($urandom), mdat[i]);
         end
         mflush = ($urandom_range(7) == 0);
         flush = mflush;
         for (int i = 0; i < N; i++) fu_valid[i] = mv[i];
         exp_i = -1;
         if (!mflush)
            for (int k = N - 1; k >= 0; k--) if (mv[(mptr + k) % N]) exp_i = (mptr + k) % N;
         #1;
         chk("soak_ready", 32'(fu_ready), (exp_i < 0) ? 0 : (32'd1 << exp_i));
         @(posedge clk); #1;
         chk("soak_valid", 32'(cdb_valid), 32'(exp_i >= 0));
         if (exp_i >= 0) begin
            chk("soak_src", 32'(cdb_src), 32'(exp_i));
            chk("soak_tag", 32'(cdb_tag), 32'(mtag[exp_i]));
            chk("soak_data", cdb_data, mdat[exp_i]);
            chk("soak_starve", 32'(mwait[exp_i] < N), 1);
            mv[exp_i] = 1'b0; mwait[exp_i] = 0;
            mptr = (exp_i + 1) % N;
         end
         if (!mflush) for (int i = 0; i < N; i++) if (mv[i]) mwait[i]++;
      end
      @(negedge clk); fu_valid = '0; flush = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
